seg_mux_disp: RTL

Parametrised multiplexed 7-segment display driver: converts a binary value to BCD with a sequential double-dabble engine and scans it across `DIGITS` common-anode digits. Adds load/busy handshake, overflow indication, leading-zero blanking with sign placement, and a configurable scan rate. Sits between register/status logic and the board's digit-select and segment pins.

---
 rtl/seg_pkg.sv | 45 ++++
 rtl/seg_mux_disp_bin2bcd.sv | 64 ++++++
 rtl/seg_mux_disp.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared digit codes, FSM state type and helper functions for the
// multiplexed 7-segment display driver (seg_mux_disp).
package seg_pkg;

   // Display buffer digit codes: 0..9 are decimal digits, then two specials.
   localparam logic [3:0] SEG_BLANK = 4'd10;
   localparam logic [3:0] SEG_MINUS = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONV    = 2'd1,
      ST_COMPOSE = 2'd2
   } disp_state_t;

   // Active-high segment pattern {g,f,e,d,c,b,a} for a digit code.
   function automatic logic [6:0] seg_glyph(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'd0:      g = 7'h3F;
         4'd1:      g = 7'h06;
         4'd2:      g = 7'h5B;
         4'd3:      g = 7'h4F;
         4'd4:      g = 7'h66;
         4'd5:      g = 7'h6D;
         4'd6:      g = 7'h7D;
         4'd7:      g = 7'h07;
         4'd8:      g = 7'h7F;
         4'd9:      g = 7'h6F;
         SEG_MINUS: g = 7'h40;
         default:   g = 7'h00;
      endcase
      return g;
   endfunction

   // 10^n, used at elaboration time for the overflow limit (n <= 9).
   function automatic logic [31:0] pow10(input int unsigned n);
      logic [31:0] r;
      r = 32'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 32'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_mux_disp_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter, one shift-add-3 iteration
// per clock. Keeps 4*DIGITS BCD bits; carries beyond the top digit are lost.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0]   sr;
   logic [4*DIGITS-1:0] bcd_q;
   logic [4*DIGITS-1:0] bcd_adj;
   logic [CNT_W-1:0]    cnt;
   logic                run;

   // Add 3 to every BCD digit that is 5 or more before the next shift.
   always_comb begin
      bcd_adj = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] +
                             ((bcd_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
      end
   end

   // Shift register, BCD accumulator and iteration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr    <= '0;
         bcd_q <= '0;
         cnt   <= '0;
         run   <= 1'b0;
      end else if (start) begin
         sr    <= bin;
         bcd_q <= '0;
         cnt   <= '0;
         run   <= 1'b1;
      end else if (run) begin
         bcd_q <= {bcd_adj[4*DIGITS-2:0], sr[DATA_W-1]};
         sr    <= {sr[DATA_W-2:0], 1'b0};
         cnt   <= cnt + 1'b1;
         if (cnt == CNT_LAST) begin
            run <= 1'b0;
         end
      end
   end

   // done marks the cycle whose closing edge performs the final iteration,
   // so the result is valid in bcd from the following cycle on.
   assign done = run && (cnt == CNT_LAST);
   assign busy = run;
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg_mux_disp.sv
// seg_mux_disp: multiplexed common-anode 7-segment display driver.
// Converts a binary value to BCD, composes digits with leading-zero blanking,
// sign placement and overflow dashes, and scans them across DIGITS digits.
// Optional feature macro: SEG_DIM_EN adds a 4-bit `bright` duty control.
module seg_mux_disp
   import seg_pkg::*;
#(
   parameter int DIGITS         = 6,
   parameter int DATA_W         = 20,
   parameter int CLK_DIV        = 10,
   parameter int SCAN_CNT       = 5000,
   parameter bit SEL_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [DATA_W-1:0]   data,
   input  logic [DIGITS-1:0]   point,
   input  logic                sign,
   input  logic                load,
   input  logic                en,
`ifdef SEG_DIM_EN
   input  logic [3:0]          bright,
`endif
   output logic                busy,
   output logic                overflow,
   output logic [DIGITS-1:0]   seg_sel,
   output logic [7:0]          seg_led
);

   localparam int PS_W  = $clog2(CLK_DIV);
   localparam int DW_W  = $clog2(SCAN_CNT + 1);
   localparam int SEL_W = $clog2(DIGITS);
   localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(CLK_DIV - 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_CNT - 1);
   localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(DIGITS - 1);
   localparam logic [31:0]      OVF_LIMIT  = pow10(DIGITS) - 32'd1;
   localparam logic [DIGITS-1:0] SEL_INV   = {DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [7:0]       SEG_INV    = {8{SEG_ACTIVE_LOW}};

   disp_state_t state, state_nxt;

   // Conversion start selection
   logic                conv_start;
   logic [DATA_W-1:0]   start_data;
   logic [DIGITS-1:0]   start_point;
   logic                start_sign;
   logic                pend_set;
   logic                pend_clr;

   // Shadow of the value under conversion and the pending slot
   logic [DIGITS-1:0]   sh_point;
   logic                sh_sign;
   logic                sh_ovf;
   logic                pend;
   logic [DATA_W-1:0]   pd_data;
   logic [DIGITS-1:0]   pd_point;
   logic                pd_sign;

   // Converter interface
   logic                conv_busy;
   logic                conv_done;
   logic [4*DIGITS-1:0] conv_bcd;

   // Compose results and display buffer
   int unsigned                comp_k;
   logic [DIGITS-1:0][3:0]     comp_code;
   logic [DIGITS-1:0]          comp_dp;
   logic [DIGITS-1:0][3:0]     buf_code;
   logic [DIGITS-1:0]          buf_dp;
   logic                       ovf_q;

   // Scan
   logic [PS_W-1:0]     presc;
   logic [DW_W-1:0]     dwell;
   logic [SEL_W-1:0]    sel;
   logic                tick;
   logic                lit;
   logic [3:0]          cur_code;
   logic                cur_dp;
   logic [DIGITS-1:0]   sel_onehot;

   bin2bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_bcd (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .start (conv_start),
      .bin   (start_data),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and conversion start; a load arriving in the compose cycle
   // is newer than anything pending, so it is converted directly.
   always_comb begin
      state_nxt   = state;
      conv_start  = 1'b0;
      start_data  = data;
      start_point = point;
      start_sign  = sign;
      pend_set    = 1'b0;
      pend_clr    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load) begin
               conv_start = 1'b1;
               state_nxt  = ST_CONV;
            end
         end
         ST_CONV: begin
            if (load) begin
               pend_set = 1'b1;
            end
            if (conv_done) begin
               state_nxt = ST_COMPOSE;
            end
         end
         ST_COMPOSE: begin
            if (load) begin
               conv_start = 1'b1;
               pend_clr   = 1'b1;
               state_nxt  = ST_CONV;
            end else if (pend) begin
               conv_start  = 1'b1;
               pend_clr    = 1'b1;
               start_data  = pd_data;
               start_point = pd_point;
               start_sign  = pd_sign;
               state_nxt   = ST_CONV;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Shadow capture at conversion start and the latest-wins pending slot.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sh_point <= '0;
         sh_sign  <= 1'b0;
         sh_ovf   <= 1'b0;
         pend     <= 1'b0;
         pd_data  <= '0;
         pd_point <= '0;
         pd_sign  <= 1'b0;
      end else begin
         if (conv_start) begin
            sh_point <= start_point;
            sh_sign  <= start_sign;
            sh_ovf   <= 32'(start_data) > OVF_LIMIT;
         end
         if (pend_clr) begin
            pend <= 1'b0;
         end else if (pend_set) begin
            pend     <= 1'b1;
            pd_data  <= data;
            pd_point <= point;
            pd_sign  <= sign;
         end
      end
   end

   // Compose digit codes: blank above the highest significant position k,
   // minus just above k when signed and room remains.
   always_comb begin
      comp_k    = 0;
      comp_code = '0;
      comp_dp   = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if ((conv_bcd[4*i +: 4] != 4'd0) || sh_point[i]) begin
            comp_k = i;
         end
      end
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (sh_ovf) begin
            comp_code[i] = SEG_MINUS;
         end else if (i <= comp_k) begin
            comp_code[i] = conv_bcd[4*i +: 4];
            comp_dp[i]   = sh_point[i];
         end else if (sh_sign && (i == comp_k + 1)) begin
            comp_code[i] = SEG_MINUS;
         end else begin
            comp_code[i] = SEG_BLANK;
         end
      end
   end

   // Display buffer and overflow flag, replaced atomically in compose.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         buf_code <= {DIGITS{SEG_BLANK}};
         buf_dp   <= '0;
         ovf_q    <= 1'b0;
      end else if (state == ST_COMPOSE) begin
         buf_code <= comp_code;
         buf_dp   <= comp_dp;
         ovf_q    <= sh_ovf;
      end
   end

   assign busy     = (state != ST_IDLE) || conv_busy;
   assign overflow = ovf_q;

   // Prescaler, dwell counter and digit position; free-running.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         presc <= '0;
         dwell <= '0;
         sel   <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            if (dwell == DWELL_LAST) begin
               dwell <= '0;
               sel   <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
            end else begin
               dwell <= dwell + 1'b1;
            end
         end
      end
   end

   assign tick = (presc == PS_LAST);

   // Selected digit's code and dot, plus its one-hot select.
   always_comb begin
      cur_code   = SEG_BLANK;
      cur_dp     = 1'b0;
      sel_onehot = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (sel == SEL_W'(i)) begin
            cur_code      = buf_code[i];
            cur_dp        = buf_dp[i];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // Duty window within the dwell; always lit without the dimming feature.
`ifdef SEG_DIM_EN
   logic [31:0] duty;
   always_comb begin
      duty = ((32'(bright) + 32'd1) * 32'(SCAN_CNT)) >> 4;
      lit  = 32'(dwell) < duty;
   end
`else
   always_comb begin
      lit = 1'b1;
   end
`endif

   // Registered pin drivers with polarity applied.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         seg_sel <= SEL_INV;
         seg_led <= SEG_INV;
      end else if (en && lit) begin
         seg_sel <= sel_onehot ^ SEL_INV;
         seg_led <= {cur_dp, seg_glyph(cur_code)} ^ SEG_INV;
      end else begin
         seg_sel <= SEL_INV;
         seg_led <= SEG_INV;
      end
   end

endmodule
